// File: rtl/axi_lite_aes_regs.sv
// AXI4-Lite register file for the AES accelerator: CTRL/KEY/DIN are host-writable,
// STATUS/DOUT are live views of the core, with one outstanding read and one outstanding write.
module axi_lite_aes_regs #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [31:0]           ctrl_reg,
  input  logic                  aes_start,
  input  logic [31:0]           status_reg,
  output logic [127:0]          aes_key,
  output logic [127:0]          aes_din,
  input  logic [127:0]          aes_dout
);

  localparam int WW = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    REG_CTRL, REG_STATUS, REG_KEY, REG_DIN, REG_DOUT, REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode(input logic [WW-1:0] widx);
    reg_sel_e sel;
    sel = REG_NONE;
    if (widx == WW'(0))                     sel = REG_CTRL;
    else if (widx == WW'(1))                sel = REG_STATUS;
    else if (widx[WW-1:2] == (WW-2)'(1))    sel = REG_KEY;
    else if (widx[WW-1:2] == (WW-2)'(2))    sel = REG_DIN;
    else if (widx[WW-1:2] == (WW-2)'(3))    sel = REG_DOUT;
    return sel;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    return res;
  endfunction

  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:2] aw_addr;
  logic [31:0]           w_data;
  logic [3:0]            w_strb;
  logic [31:0]           key [4];
  logic [31:0]           din [4];
  logic [31:0]           dout_w [4];
  logic                  aw_hs, w_hs, ar_hs, commit;
  logic                  aw_held_d, w_held_d, bvalid_d, rvalid_d;
  reg_sel_e              wr_sel, rd_sel;
  logic [1:0]            wr_idx, rd_idx;
  logic [31:0]           rd_data;
  logic                  rd_err;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign ar_hs  = s_axi_arvalid & s_axi_arready;
  assign commit = aw_held & w_held;
  assign wr_sel = decode(aw_addr);
  assign wr_idx = aw_addr[3:2];
  assign rd_sel = decode(s_axi_araddr[ADDR_WIDTH-1:2]);
  assign rd_idx = s_axi_araddr[3:2];

  assign aes_key = {key[3], key[2], key[1], key[0]};
  assign aes_din = {din[3], din[2], din[1], din[0]};

  // Ready flags are registered from next-state so they are 0 in reset and follow the hold rules exactly.
  always_comb begin
    aw_held_d = commit ? 1'b0 : (aw_held | aw_hs);
    w_held_d  = commit ? 1'b0 : (w_held | w_hs);
    bvalid_d  = commit | (s_axi_bvalid & ~s_axi_bready);
    rvalid_d  = ar_hs | (s_axi_rvalid & ~s_axi_rready);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) dout_w[i] = aes_dout[32*i +: 32];
  end

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (rd_sel)
      REG_CTRL:   rd_data = ctrl_reg;
      REG_STATUS: rd_data = status_reg;
      REG_KEY:    rd_data = key[rd_idx];
      REG_DIN:    rd_data = din[rd_idx];
      REG_DOUT:   rd_data = dout_w[rd_idx];
      default:    rd_err  = 1'b1;
    endcase
  end

  // A committing CTRL write takes priority over the START clear from the core.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      ctrl_reg      <= '0;
      for (int i = 0; i < 4; i++) begin
        key[i] <= '0;
        din[i] <= '0;
      end
    end else begin
      aw_held       <= aw_held_d;
      w_held        <= w_held_d;
      s_axi_awready <= ~aw_held_d & ~bvalid_d;
      s_axi_wready  <= ~w_held_d & ~bvalid_d;
      s_axi_bvalid  <= bvalid_d;
      if (aw_hs) aw_addr <= s_axi_awaddr[ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (commit)
        s_axi_bresp <= (wr_sel inside {REG_CTRL, REG_KEY, REG_DIN}) ? RESP_OKAY : RESP_SLVERR;
      if (commit && wr_sel == REG_CTRL) ctrl_reg <= merge(ctrl_reg, w_data, w_strb);
      else if (aes_start)               ctrl_reg[0] <= 1'b0;
      if (commit && wr_sel == REG_KEY)  key[wr_idx] <= merge(key[wr_idx], w_data, w_strb);
      if (commit && wr_sel == REG_DIN)  din[wr_idx] <= merge(din[wr_idx], w_data, w_strb);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      s_axi_rvalid  <= rvalid_d;
      s_axi_arready <= ~rvalid_d;
      if (ar_hs) begin
        s_axi_rdata <= rd_data;
        s_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule
